barrel_shifter_pipe: RTL and testbench

//  Parametrised, pipelined log-stage barrel shifter. It succeeds the 8-bit combinational SRA mux chain.
//  - Ops: SLL, SRL, SRA, ROR, on a WIDTH-bit operand.
//  - One registered mux stage per shift-amount bit.
//  - Valid/ready handshake on input and output.
//  - Sits in the arithmetic datapath between the operand fetch stage and the result writeback.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_stage.sv | 45 ++++
 rtl/barrel_shifter_pipe.sv | 48 ++++
 tb/tb_barrel_shifter_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shift op encoding and the single-stage power-of-two shift shared by the stages
package shift_pkg;
  typedef enum logic [1:0] {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR} shift_op_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] shift_by_pow2(shift_op_t op, logic [MAX_W-1:0] data, int unsigned k, int unsigned w);
    logic [MAX_W-1:0] m, d, fill;
    int unsigned n;
    n = 1 << k;
    m = {MAX_W{1'b1}} >> (MAX_W - w);
    d = data & m;
    fill = d[w-1] ? (m & ~(m >> n)) : '0;
    return op == SHIFT_SLL ? (d << n) & m :
           op == SHIFT_SRL ? d >> n :
           op == SHIFT_SRA ? (d >> n) | fill :
                             ((d >> n) | (d << (w - n))) & m;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one conditional 2^K shift with its pipeline register and handshake
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHAMT_W = 3,
  parameter int TAG_W = 4,
  parameter int K = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [1:0]         up_op,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic [TAG_W-1:0]   up_tag,
  input  logic               down_ready,
  output logic               valid,
  output logic [1:0]         op,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] shamt,
  output logic [TAG_W-1:0]   tag
);
  logic [WIDTH-1:0] shifted;
  assign up_ready = !valid || down_ready;
  assign shifted = up_shamt[K] ? WIDTH'(shift_by_pow2(shift_op_t'(up_op), MAX_W'(up_data), K, WIDTH)) : up_data;
  // load a new beat (or bubble) whenever this stage is empty or its content moves on
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      op <= '0;
      data <= '0;
      shamt <= '0;
      tag <= '0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) begin
        op <= up_op;
        data <= shifted;
        shamt <= up_shamt;
        tag <= up_tag;
      end
    end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined log-stage barrel shifter (SLL/SRL/SRA/ROR) with valid/ready
module barrel_shifter_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);
  logic               v [SHAMT_W+1];
  logic               r [SHAMT_W+1];
  logic [1:0]         o [SHAMT_W+1];
  logic [WIDTH-1:0]   d [SHAMT_W+1];
  logic [SHAMT_W-1:0] s [SHAMT_W+1];
  logic [TAG_W-1:0]   t [SHAMT_W+1];
  assign v[0] = in_valid;
  assign o[0] = in_op;
  assign d[0] = in_data;
  assign s[0] = in_shamt;
  assign t[0] = in_tag;
  assign r[SHAMT_W] = out_ready;
  assign in_ready = r[0];
  assign out_valid = v[SHAMT_W];
  assign out_data = d[SHAMT_W];
  assign out_tag = t[SHAMT_W];
  assign out_zero = ~|out_data;
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W), .K(k)) u_stage (
      .clk(clk), .rst_n(rst_n),
      .up_valid(v[k]), .up_ready(r[k]), .up_op(o[k]), .up_data(d[k]), .up_shamt(s[k]), .up_tag(t[k]),
      .down_ready(r[k+1]),
      .valid(v[k+1]), .op(o[k+1]), .data(d[k+1]), .shamt(s[k+1]), .tag(t[k+1])
    );
  end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed checks of the 8-bit shifter plus a 32-bit random regression
module tb_barrel_shifter_pipe;
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_zero;
  logic [1:0] a_in_op = 0;
  logic [7:0] a_in_data = 0, a_out_data;
  logic [2:0] a_in_shamt = 0;
  logic [3:0] a_in_tag = 0, a_out_tag;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_zero;
  logic [1:0] b_in_op = 0;
  logic [31:0] b_in_data = 0, b_out_data;
  logic [4:0] b_in_shamt = 0;
  logic [3:0] b_in_tag = 0, b_out_tag;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
    .in_data(a_in_data), .in_shamt(a_in_shamt), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag), .out_zero(a_out_zero));

  barrel_shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_data(b_in_data), .in_shamt(b_in_shamt), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag), .out_zero(b_out_zero));

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] d, int s, int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      r[i] = op == 0 ? (i >= s ? d[i-s] : 1'b0) :
             op == 1 ? (i + s < w ? d[i+s] : 1'b0) :
             op == 2 ? (i + s < w ? d[i+s] : d[w-1]) :
                       d[(i+s)%w];
    return r;
  endfunction

  task automatic send_one(input logic [1:0] op, input logic [7:0] data, input logic [2:0] sh, input logic [3:0] tag,
                          output logic [7:0] od, output logic [3:0] ot, output logic oz, output int lat);
    @(negedge clk);
    a_in_valid = 1; a_in_op = op; a_in_data = data; a_in_shamt = sh; a_in_tag = tag;
    @(negedge clk);
    a_in_valid = 0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    od = a_out_data; ot = a_out_tag; oz = a_out_zero;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_tag !== 4'h0 || a_out_zero !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h t=%h z=%b rdy=%b want v=0 d=00 t=0 z=1 rdy=1",
               a_out_valid, a_out_data, a_out_tag, a_out_zero, a_in_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_ops();
    logic [7:0] exp [4] = '{8'hB0, 8'h12, 8'hF2, 8'hD2};
    logic [7:0] od;
    logic [3:0] ot;
    logic oz;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_one(2'(i), 8'h96, 3'd3, 4'(i + 8), od, ot, oz, lat);
      checks++;
      if (od !== exp[i]) begin errors++; $display("FAIL ops_data op=%0d got %h want %h", i, od, exp[i]); end
      checks++;
      if (ot !== 4'(i + 8)) begin errors++; $display("FAIL ops_tag op=%0d got %h want %h", i, ot, 4'(i + 8)); end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL ops_latency op=%0d got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [16];
    a_out_ready = 1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j >= 3 && j < 19) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== exp[j-3] || a_out_tag !== 4'(j - 3)) begin
          errors++;
          $display("FAIL b2b_out beat=%0d got v=%b d=%h t=%h want v=1 d=%h t=%h",
                   j - 3, a_out_valid, a_out_data, a_out_tag, exp[j-3], 4'(j - 3));
        end
      end
      if (j < 16) begin
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat=%0d got %b want 1", j, a_in_ready); end
        a_in_valid = 1; a_in_op = 2'($urandom_range(0, 3)); a_in_data = 8'($urandom);
        a_in_shamt = 3'($urandom_range(0, 7)); a_in_tag = 4'(j);
        exp[j] = 8'(ref_shift(a_in_op, 32'(a_in_data), int'(a_in_shamt), 8));
      end else a_in_valid = 0;
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [6];
    int sent = 0, rcv = 0;
    for (int i = 0; i < 6; i++) exp[i] = 8'(ref_shift(2'(i % 4), 32'(8'h11 * (i + 1)), i + 1, 8));
    @(negedge clk);
    for (int t = 0; t < 50 && rcv < 6; t++) begin
      a_out_ready = t >= 6;
      #1;
      if (t < 6) begin
        checks++;
        if (a_in_ready !== (t < 3)) begin errors++; $display("FAIL stall_in_ready cyc=%0d got %b want %b", t, a_in_ready, t < 3); end
      end
      if (t >= 3 && t < 6) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== exp[0] || a_out_tag !== 4'd0) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h t=%h want v=1 d=%h t=0", t, a_out_valid, a_out_data, a_out_tag, exp[0]);
        end
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_data !== exp[rcv] || a_out_tag !== 4'(rcv)) begin
          errors++;
          $display("FAIL stall_order beat=%0d got d=%h t=%h want d=%h t=%h", rcv, a_out_data, a_out_tag, exp[rcv], 4'(rcv));
        end
        rcv++;
      end
      a_in_valid = sent < 6;
      if (sent < 6) begin
        a_in_op = 2'(sent % 4); a_in_data = 8'(8'h11 * (sent + 1)); a_in_shamt = 3'(sent + 1); a_in_tag = 4'(sent);
      end
      if (a_in_valid && a_in_ready) sent++;
      @(negedge clk);
    end
    a_in_valid = 0;
    a_out_ready = 1;
    checks++;
    if (rcv !== 6) begin errors++; $display("FAIL stall_count got %0d want 6", rcv); end
  endtask

  task automatic test_boundary();
    logic [1:0] ops [7] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [7:0] din [7] = '{8'h80, 8'h01, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h01};
    logic [2:0] sh [7] = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [7:0] exp [7] = '{8'hFF, 8'h80, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00};
    logic zexp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] od;
    logic [3:0] ot;
    logic oz;
    int lat;
    for (int i = 0; i < 7; i++) begin
      send_one(ops[i], din[i], sh[i], 4'(i), od, ot, oz, lat);
      checks++;
      if (od !== exp[i] || oz !== zexp[i] || lat !== 3) begin
        errors++;
        $display("FAIL boundary vec=%0d got d=%h z=%b lat=%0d want d=%h z=%b lat=3", i, od, oz, lat, exp[i], zexp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic stale = 0;
    a_out_ready = 0;
    @(negedge clk);
    a_in_valid = 1; a_in_op = 2'd0; a_in_data = 8'h0F; a_in_shamt = 3'd1; a_in_tag = 4'hA;
    @(negedge clk);
    a_in_tag = 4'hB;
    @(negedge clk);
    a_in_valid = 0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b want 1", a_out_valid); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00 || a_out_zero !== 1'b1) begin
      errors++;
      $display("FAIL arst_outputs got v=%b rdy=%b d=%h z=%b want v=0 rdy=1 d=00 z=1", a_out_valid, a_in_ready, a_out_data, a_out_zero);
    end
    @(negedge clk);
    rst_n = 1;
    a_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_out_valid) stale = 1;
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL arst_stale got valid beat after release want none"); end
  endtask

  task automatic test_wide();
    logic [35:0] q [$];
    int sent = 0, rcv = 0, lat;
    for (int t = 0; t < 20000 && rcv < 1000; t++) begin
      b_out_ready = $urandom_range(0, 3) != 0;
      b_in_valid = sent < 1000 && $urandom_range(0, 3) != 0;
      b_in_op = 2'($urandom_range(0, 3)); b_in_data = $urandom; b_in_shamt = 5'($urandom_range(0, 31)); b_in_tag = 4'(sent);
      #1;
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (q.size() == 0 || {b_out_tag, b_out_data} !== q[0] || b_out_zero !== (b_out_data == 0)) begin
          errors++;
          $display("FAIL wide_beat n=%0d got t=%h d=%h z=%b want %h", rcv, b_out_tag, b_out_data, b_out_zero, q.size() ? q[0] : 36'h0);
        end
        if (q.size() != 0) void'(q.pop_front());
        rcv++;
      end
      if (b_in_valid && b_in_ready) begin
        q.push_back({b_in_tag, ref_shift(b_in_op, b_in_data, int'(b_in_shamt), 32)});
        sent++;
      end
      @(negedge clk);
    end
    b_in_valid = 0;
    b_out_ready = 1;
    checks++;
    if (rcv !== 1000) begin errors++; $display("FAIL wide_count got %0d want 1000", rcv); end
    @(negedge clk);
    @(negedge clk);
    b_in_valid = 1; b_in_op = 2'd3; b_in_data = 32'h0000_00F1; b_in_shamt = 5'd4; b_in_tag = 4'h5;
    @(negedge clk);
    b_in_valid = 0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 5 || b_out_data !== 32'h1000_000F || b_out_tag !== 4'h5) begin
      errors++;
      $display("FAIL wide_latency got lat=%0d d=%h t=%h want lat=5 d=1000000f t=5", lat, b_out_data, b_out_tag);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_stall();
    test_boundary();
    test_async_reset();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
